traffic_sensor_conditioner: RTL and testbench
=============================================

# traffic_sensor_conditioner

Conditions the raw vehicle-detector inputs for streets A and B into the clean `ta`/`tb` traffic-present flags that drive the traffic-light controller directly downstream. Each sensor is synchronised and debounced. The result is qualified against the controller's current lamp outputs (`la`/`lb`, fed back) to enforce a minimum green time. Optionally, a starvation guard caps green time when cross traffic waits.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles needed to accept a sensor change; must be ≥1.
- `MIN_GREEN`, default 8: cycles a green is held regardless of traffic; must be ≥1.
- `MAX_GREEN`, default 32: green cycles after which a waiting cross street forces release; must be > `MIN_GREEN`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `sens_a_raw` in 1: asynchronous detector, street A.
- `sens_b_raw` in 1: asynchronous detector, street B.
- `la` in 2: lamp state of A from the controller (GREEN=2'b00, YELLOW=2'b01, RED=2'b10; 2'b11 is treated as not green).
- `lb` in 2: lamp state of B, same encoding.
- `ta` out 1: traffic present on A; holds A green.
- `tb` out 1: traffic present on B; holds B green.
- `starve_a` out 1: starvation guard is currently forcing `ta` low.
- `starve_b` out 1: starvation guard is currently forcing `tb` low.

## Operation
- **Synchroniser:** 2-flop per sensor, producing `s_a`/`s_b`.
- **Debounce (per channel):**
  - Holds debounced value `deb_x` and counter `db_cnt` (width `$clog2(DEBOUNCE_CYCLES+1)`).
  - If `s_x == deb_x`, `db_cnt` clears to 0.
  - Otherwise, if `db_cnt == DEBOUNCE_CYCLES-1`, `deb_x` takes `s_x` and `db_cnt` clears; else `db_cnt` increments.
  - A glitch shorter than `DEBOUNCE_CYCLES` sampled cycles never reaches `deb_x`.
- **Green timer (per direction):**
  - `g_cnt_x` (width `$clog2(MAX_GREEN+1)`) increments each cycle `lx == GREEN`, saturating at `MAX_GREEN`.
  - It clears to 0 on any cycle `lx != GREEN`.
- **Output qualification, in priority order, for `ta` (`tb` is symmetric with A↔B swapped):**
  1. `la == GREEN` and `g_cnt_a < MIN_GREEN` → `ta_next = 1` (minimum-green hold).
  2. Guard compiled in, `la == GREEN`, `g_cnt_a >= MAX_GREEN` and `deb_b == 1` → `ta_next = 0`, `starve_a_next = 1`.
  3. Otherwise `ta_next = deb_a`, `starve_a_next = 0`.
- `ta`, `tb`, `starve_a` and `starve_b` are registered.
- No FSM beyond the per-channel debounce/counter state; both channels are fully independent except that the starvation condition reads the cross street's `deb`.
- **Reset:** sync flops, `deb_*`, all counters and all outputs go to 0. Reset asserted mid-debounce or mid-green discards all progress. The first cycle after reset behaves as a fresh start.

## Timing
- **Sensor latency:** raw change first sampled at edge 1; `s_x` valid at edge 2; `deb_x` updates at edge `DEBOUNCE_CYCLES+2`; `ta`/`tb` change at edge `DEBOUNCE_CYCLES+3` (7 with defaults), provided no qualification rule overrides.
- **Lamp-feedback latency:** `lx` is used combinationally into the next-state logic, so output effects appear 1 edge after the lamp input changes.
- **Minimum-green hold:** with `la` going GREEN at edge k, `ta` is forced 1 from edge k+1 through edge k+`MIN_GREEN`.
- **Starvation:** `starve_a` rises at edge k+`MAX_GREEN`+1 if `deb_b` is 1.
  - It falls 1 edge after `la` leaves GREEN or `deb_b` drops.
- **Simultaneous toggle:** a raw toggle landing on the same edge the counter would complete restarts the count; no partial credit.
- **Counter bounds:** counters never wrap.

## Configuration
- Macro `TRAFFIC_STARVE_GUARD_EN`.
- **Defined:** rule 2 is active and `starve_a`/`starve_b` behave as above.
- **Undefined:**
  - Rule 2 is removed.
  - `starve_a`/`starve_b` are tied to 0.
  - `g_cnt` saturates at `MIN_GREEN` instead of `MAX_GREEN`, with width sized accordingly.
  - The `MAX_GREEN` parameter remains present but unused.

## Test plan
- **Reset values:** hold `reset` for 3 cycles with sensors at 1 → `ta=tb=starve_a=starve_b=0` throughout and on the first cycle after release.
- **Debounce pass:** `la=lb=RED`, raise `sens_a_raw` steadily → `ta` rises exactly 7 edges later; `tb` stays 0.
- **Glitch reject:** `la=lb=RED`, pulse `sens_b_raw` high for 3 cycles, then low → `tb` never rises.
- **Minimum green:** `sens_a_raw=0`, drive `la=GREEN` from edge k → `ta=1` for edges k+1..k+8, then `ta=0` at edge k+9.
- **Starvation guard (macro defined):** `sens_a_raw=1`, `sens_b_raw=1` debounced, `la=GREEN` from edge k → `ta=1` until edge k+32; `ta=0` and `starve_a=1` at edge k+33. Setting `la=YELLOW` then gives `starve_a=0` and `ta=1` 1 edge later.
- **Guard compiled out:** repeat the previous scenario without `TRAFFIC_STARVE_GUARD_EN` → `ta` stays 1 indefinitely and `starve_a` stays 0.

Source files
------------

// File: rtl/traffic_sensor_conditioner.sv
// Synchronises, debounces and lamp-qualifies the A/B vehicle detectors into ta/tb.
// Optional starvation guard enabled by defining TRAFFIC_STARVE_GUARD_EN.
module traffic_sensor_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int MIN_GREEN       = 8,
   parameter int MAX_GREEN       = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sens_a_raw,
   input  logic       sens_b_raw,
   input  logic [1:0] la,
   input  logic [1:0] lb,
   output logic       ta,
   output logic       tb,
   output logic       starve_a,
   output logic       starve_b
);

`ifdef TRAFFIC_STARVE_GUARD_EN
   localparam int G_SAT = MAX_GREEN;
`else
   localparam int G_SAT = MIN_GREEN;
`endif
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int GW = $clog2(G_SAT + 1);
   localparam logic [1:0] GREEN = 2'b00;

   generate
      if (DEBOUNCE_CYCLES < 1) begin : g_chk_db
         $error("DEBOUNCE_CYCLES must be >= 1");
      end
      if (MIN_GREEN < 1 || MAX_GREEN <= MIN_GREEN) begin : g_chk_green
         $error("need 1 <= MIN_GREEN < MAX_GREEN");
      end
   endgenerate

   // Index 0 is street A, index 1 is street B throughout.
   logic [1:0]         meta_q, meta_d, sync_q, sync_d;
   logic [1:0]         deb_q, deb_d, t_q, t_d, starve_q, starve_d;
   logic [1:0][DW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0][GW-1:0] g_cnt_q, g_cnt_d;
   logic [1:0]         green;

   assign green = {lb == GREEN, la == GREEN};

   always_comb begin
      meta_d   = {sens_b_raw, sens_a_raw};
      sync_d   = meta_q;
      deb_d    = deb_q;
      db_cnt_d = db_cnt_q;
      g_cnt_d  = g_cnt_q;
      t_d      = deb_q;
      starve_d = '0;
      for (int i = 0; i < 2; i++) begin
         // Any return to the accepted value restarts the stability count.
         if (sync_q[i] == deb_q[i]) begin
            db_cnt_d[i] = '0;
         end else if (db_cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
            deb_d[i]    = sync_q[i];
            db_cnt_d[i] = '0;
         end else begin
            db_cnt_d[i] = db_cnt_q[i] + DW'(1);
         end

         if (!green[i]) begin
            g_cnt_d[i] = '0;
         end else if (g_cnt_q[i] != GW'(G_SAT)) begin
            g_cnt_d[i] = g_cnt_q[i] + GW'(1);
         end

         if (green[i] && g_cnt_q[i] < GW'(MIN_GREEN)) begin
            t_d[i] = 1'b1;
         end
`ifdef TRAFFIC_STARVE_GUARD_EN
         else if (green[i] && g_cnt_q[i] >= GW'(MAX_GREEN) && deb_q[1-i]) begin
            t_d[i]      = 1'b0;
            starve_d[i] = 1'b1;
         end
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q   <= '0;
         sync_q   <= '0;
         deb_q    <= '0;
         db_cnt_q <= '0;
         g_cnt_q  <= '0;
         t_q      <= '0;
         starve_q <= '0;
      end else begin
         meta_q   <= meta_d;
         sync_q   <= sync_d;
         deb_q    <= deb_d;
         db_cnt_q <= db_cnt_d;
         g_cnt_q  <= g_cnt_d;
         t_q      <= t_d;
         starve_q <= starve_d;
      end
   end

   assign ta       = t_q[0];
   assign tb       = t_q[1];
   assign starve_a = starve_q[0];
   assign starve_b = starve_q[1];

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Randomised and directed bench for traffic_sensor_conditioner with a behavioural model.
module tb_traffic_sensor_conditioner;
   localparam int DEB  = 4;
   localparam int MING = 8;
   localparam int MAXG = 32;
`ifdef TRAFFIC_STARVE_GUARD_EN
   localparam bit GUARD = 1'b1;
`else
   localparam bit GUARD = 1'b0;
`endif
   localparam int GSAT = GUARD ? MAXG : MING;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic sens_a_raw = 1'b0, sens_b_raw = 1'b0;
   logic [1:0] la = 2'b10, lb = 2'b10;
   logic ta, tb, starve_a, starve_b;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   // Behavioural model state
   int r1a, r1b, r2a, r2b, da, db, runa, runb, ga, gb, mta, mtb, msa, msb;

   traffic_sensor_conditioner #(.DEBOUNCE_CYCLES(DEB), .MIN_GREEN(MING), .MAX_GREEN(MAXG)) dut (
      .clk(clk), .reset(reset), .sens_a_raw(sens_a_raw), .sens_b_raw(sens_b_raw),
      .la(la), .lb(lb), .ta(ta), .tb(tb), .starve_a(starve_a), .starve_b(starve_b));

   always #5 clk = ~clk;

   task automatic model_clear();
      r1a = 0; r1b = 0; r2a = 0; r2b = 0; da = 0; db = 0; runa = 0; runb = 0;
      ga = 0; gb = 0; mta = 0; mtb = 0; msa = 0; msb = 0;
   endtask

   // One active edge: advance the model from the pre-edge state, then compare outputs.
   task automatic tick();
      int nta, ntb, nsa, nsb;
      bit gra, grb;
      @(posedge clk);
      cyc++;
      if (reset) begin
         model_clear();
      end else begin
         gra = (la == 2'b00);
         grb = (lb == 2'b00);
         nsa = 0; nsb = 0;
         if (gra && ga < MING) nta = 1;
         else if (GUARD && gra && ga >= MAXG && db == 1) begin nta = 0; nsa = 1; end
         else nta = da;
         if (grb && gb < MING) ntb = 1;
         else if (GUARD && grb && gb >= MAXG && da == 1) begin ntb = 0; nsb = 1; end
         else ntb = db;
         // debounce: accept after DEB consecutive differing samples
         if (r2a != da) begin runa++; if (runa == DEB) begin da = r2a; runa = 0; end end
         else runa = 0;
         if (r2b != db) begin runb++; if (runb == DEB) begin db = r2b; runb = 0; end end
         else runb = 0;
         r2a = r1a; r2b = r1b;
         r1a = int'(sens_a_raw); r1b = int'(sens_b_raw);
         ga = gra ? ((ga + 1 > GSAT) ? GSAT : ga + 1) : 0;
         gb = grb ? ((gb + 1 > GSAT) ? GSAT : gb + 1) : 0;
         mta = nta; mtb = ntb; msa = nsa; msb = nsb;
      end
      #1;
      checks++;
      if ({ta, tb, starve_a, starve_b} !== {mta[0], mtb[0], msa[0], msb[0]}) begin
         errors++;
         $display("FAIL model_outputs cyc=%0d got ta,tb,sa,sb=%b%b%b%b exp=%0d%0d%0d%0d",
                  cyc, ta, tb, starve_a, starve_b, mta, mtb, msa, msb);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      sens_a_raw = 1'b0; sens_b_raw = 1'b0; la = 2'b10; lb = 2'b10;
      repeat (3) tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      sens_a_raw = 1'b1; sens_b_raw = 1'b1; la = 2'b00; lb = 2'b00;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({ta, tb, starve_a, starve_b} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold got=%b%b%b%b exp=0000", ta, tb, starve_a, starve_b);
         end
      end
      reset = 1'b0;
      la = 2'b10; lb = 2'b10;
      tick();
      checks++;
      if ({ta, tb, starve_a, starve_b} !== 4'b0000) begin
         errors++;
         $display("FAIL reset_release got=%b%b%b%b exp=0000", ta, tb, starve_a, starve_b);
      end
   endtask

   task automatic test_debounce_pass();
      do_reset();
      repeat (4) tick();
      sens_a_raw = 1'b1;
      for (int e = 1; e <= 9; e++) begin
         tick();
         checks++;
         if (ta !== (e >= DEB + 3) || tb !== 1'b0) begin
            errors++;
            $display("FAIL debounce_pass edge=%0d got ta=%b tb=%b exp ta=%0d tb=0", e, ta, tb, e >= DEB + 3);
         end
      end
   endtask

   task automatic test_glitch_reject();
      do_reset();
      sens_b_raw = 1'b1;
      repeat (3) tick();
      sens_b_raw = 1'b0;
      for (int e = 0; e < 12; e++) begin
         tick();
         checks++;
         if (tb !== 1'b0) begin
            errors++;
            $display("FAIL glitch_reject edge=%0d got tb=%b exp=0", e, tb);
         end
      end
   endtask

   task automatic test_min_green();
      do_reset();
      repeat (2) tick();
      la = 2'b00;
      for (int e = 1; e <= MING + 3; e++) begin
         tick();
         checks++;
         if (ta !== (e <= MING)) begin
            errors++;
            $display("FAIL min_green edge=%0d got ta=%b exp=%0d", e, ta, e <= MING);
         end
      end
      la = 2'b10;
   endtask

   task automatic test_starvation();
      bit exp_t, exp_s;
      do_reset();
      sens_a_raw = 1'b1; sens_b_raw = 1'b1;
      repeat (10) tick();
      la = 2'b00;
      for (int e = 1; e <= MAXG + 8; e++) begin
         tick();
         exp_s = GUARD && (e >= MAXG + 1);
         exp_t = !exp_s;
         checks++;
         if (ta !== exp_t || starve_a !== exp_s || starve_b !== 1'b0) begin
            errors++;
            $display("FAIL starvation edge=%0d got ta=%b sa=%b sb=%b exp ta=%0d sa=%0d sb=0",
                     e, ta, starve_a, starve_b, exp_t, exp_s);
         end
      end
      la = 2'b01;
      tick();
      checks++;
      if (ta !== 1'b1 || starve_a !== 1'b0) begin
         errors++;
         $display("FAIL starve_release got ta=%b sa=%b exp ta=1 sa=0", ta, starve_a);
      end
      repeat (3) tick();
      la = 2'b10;
   endtask

   task automatic test_random();
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 299) == 0);
         if ($urandom_range(0, 7) == 0) sens_a_raw = ~sens_a_raw;
         if ($urandom_range(0, 7) == 0) sens_b_raw = ~sens_b_raw;
         if ($urandom_range(0, 59) == 0) la = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 59) == 0) lb = 2'($urandom_range(0, 3));
         tick();
      end
      reset = 1'b0;
   endtask

   initial begin
      model_clear();
      test_reset();
      test_debounce_pass();
      test_glitch_reject();
      test_min_green();
      test_starvation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
